// File: rtl/ca_screen_sequencer.sv
// CA display sequencer: seed row -> one-frame engine grant -> hold -> copy last row to row 0.
// Optional key debounce enabled by defining CA_SEQ_DEBOUNCE_EN (adds parameter DEB_CYCLES).
module ca_screen_sequencer #(
  parameter int          H_PIXELS   = 640,
  parameter int          V_PIXELS   = 480,
  parameter int          PIPE_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
`ifdef CA_SEQ_DEBOUNCE_EN
  , parameter int        DEB_CYCLES = 250000
`endif
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [9:0]  x_pixel_coord_i,
  input  logic [9:0]  y_pixel_coord_i,
  input  logic [7:0]  rule_i,
  input  logic        seed_or_random_i,
  input  logic        next_screen_i,
  input  logic [15:0] mem_read_data_i,
  output logic        mem_grant_o,
  output logic        draw_enable_o,
  output logic [7:0]  rule_o,
  output logic [10:0] mem_write_address_o,
  output logic        mem_write_enable_o,
  output logic [15:0] mem_write_data_o,
  output logic [10:0] mem_read_address_o,
  output logic [2:0]  state_o,
  output logic [15:0] screen_count_o
);

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_SEED       = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_DRAW       = 3'd3,
    ST_DRAIN      = 3'd4,
    ST_HOLD       = 3'd5,
    ST_COPY       = 3'd6
  } state_t;

  localparam logic [10:0] H_W        = 11'(H_PIXELS);
  localparam logic [10:0] H_LAST     = 11'(H_PIXELS - 1);
  localparam logic [10:0] H_MID      = 11'(H_PIXELS / 2);
  localparam logic [10:0] BANK2      = 11'(2 * H_PIXELS);
  localparam logic [10:0] DRAIN_LAST = 11'(PIPE_DEPTH);
  localparam logic [9:0]  X_LAST     = 10'(H_PIXELS - 1);
  localparam logic [9:0]  Y_LAST     = 10'(V_PIXELS - 1);
  localparam logic [15:0] PIX_WHITE  = 16'hFF00;
  localparam logic [15:0] PIX_BLACK  = 16'h0000;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_next;
  logic        single_q;
  logic [7:0]  rule_q;
  logic [15:0] screen_cnt_q;
  logic        grant_q;
  logic [1:0]  key_sync_q;
  logic        key_level;
  logic        key_prev_q;
  logic        press;
  logic        seed_black;

  // Two-flop synchroniser; the key is asynchronous to the pixel clock.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      key_sync_q <= 2'b00;
    end else begin
      key_sync_q <= {key_sync_q[0], next_screen_i};
    end
  end

`ifdef CA_SEQ_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  logic [DEB_W-1:0] deb_cnt_q;
  logic             deb_level_q;

  // Level only follows the synchronised key after DEB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
    end else if (key_sync_q[1] == deb_level_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
      deb_cnt_q   <= '0;
      deb_level_q <= key_sync_q[1];
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign key_level = deb_level_q;
`else
  assign key_level = key_sync_q[1];
`endif

  assign press = key_level & ~key_prev_q;

  assign lfsr_next  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  assign seed_black = single_q ? (cnt_q == H_MID) : lfsr_q[0];

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    mem_write_address_o = '0;
    mem_write_enable_o  = 1'b0;
    mem_write_data_o    = '0;
    mem_read_address_o  = '0;
    case (state_q)
      ST_INIT: begin
        cnt_d   = '0;
        state_d = ST_SEED;
      end
      ST_SEED: begin
        mem_write_enable_o  = 1'b1;
        mem_write_address_o = cnt_q;
        mem_write_data_o    = seed_black ? PIX_BLACK : PIX_WHITE;
        if (cnt_q == H_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_FRAME;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_WAIT_FRAME: begin
        if (x_pixel_coord_i == 10'd0 && y_pixel_coord_i == 10'd0) begin
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (x_pixel_coord_i == X_LAST && y_pixel_coord_i == Y_LAST) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_HOLD: begin
        if (press) begin
          cnt_d   = '0;
          state_d = ST_COPY;
        end
      end
      ST_COPY: begin
        // Read runs one cycle ahead of the write to cover the RAM read latency.
        if (cnt_q < H_W) begin
          mem_read_address_o = BANK2 + cnt_q;
        end
        if (cnt_q != 11'd0) begin
          mem_write_enable_o  = 1'b1;
          mem_write_address_o = cnt_q - 11'd1;
          mem_write_data_o    = mem_read_data_i;
        end
        if (cnt_q == H_W) begin
          cnt_d   = '0;
          state_d = ST_WAIT_FRAME;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      single_q     <= 1'b0;
      rule_q       <= '0;
      screen_cnt_q <= '0;
      grant_q      <= 1'b0;
      key_prev_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_prev_q <= key_level;
      grant_q    <= (state_d == ST_DRAW) || (state_d == ST_DRAIN);
      if (state_q == ST_INIT) begin
        rule_q   <= rule_i;
        single_q <= seed_or_random_i;
      end
      if (state_q == ST_SEED) begin
        lfsr_q <= lfsr_next;
      end
      if (state_q == ST_DRAIN && state_d == ST_HOLD) begin
        screen_cnt_q <= screen_cnt_q + 16'd1;
      end
    end
  end

  assign mem_grant_o    = grant_q;
  assign draw_enable_o  = grant_q;
  assign rule_o         = rule_q;
  assign state_o        = state_q;
  assign screen_count_o = screen_cnt_q;

endmodule

// File: tb/tb_ca_screen_sequencer.sv
// Directed bench for ca_screen_sequencer with H=16, V=4, PIPE_DEPTH=3 and a small registered RAM model.
module tb_ca_screen_sequencer;

  localparam int H = 16;
  localparam int V = 4;
  localparam int PD = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  x = 10'd5;
  logic [9:0]  y = 10'd2;
  logic [7:0]  rule_in = 8'd30;
  logic        seed_sel = 1'b1;
  logic        next_screen = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        grant, enable, we;
  logic [7:0]  rule_out;
  logic [10:0] wa, ra;
  logic [15:0] wd, screen_cnt;
  logic [2:0]  state;

  logic        sweep_en = 1'b0;
  logic [9:0]  sx, sy;
  int          total = 0;
  int          bad = 0;

  ca_screen_sequencer #(
    .H_PIXELS(H), .V_PIXELS(V), .PIPE_DEPTH(PD), .LFSR_SEED(16'hACE1)
`ifdef CA_SEQ_DEBOUNCE_EN
    , .DEB_CYCLES(8)
`endif
  ) dut (
    .clock_i(clk), .reset_i(rst),
    .x_pixel_coord_i(x), .y_pixel_coord_i(y),
    .rule_i(rule_in), .seed_or_random_i(seed_sel), .next_screen_i(next_screen),
    .mem_read_data_i(rd_data),
    .mem_grant_o(grant), .draw_enable_o(enable), .rule_o(rule_out),
    .mem_write_address_o(wa), .mem_write_enable_o(we), .mem_write_data_o(wd),
    .mem_read_address_o(ra), .state_o(state), .screen_count_o(screen_cnt)
  );

  always #5 clk = ~clk;

  // RAM contents are a fixed pattern of the address, with one-cycle read latency.
  always @(posedge clk) rd_data <= 16'h5A00 | {5'd0, ra};

  task automatic tick();
    @(posedge clk);
    #1;
    sx = x;
    sy = y;
    if (sweep_en) begin
      if (x == 10'(H - 1)) begin
        x = 10'd0;
        y = (y == 10'(V - 1)) ? 10'd0 : y + 10'd1;
      end else begin
        x = x + 10'd1;
      end
    end
  endtask

  task automatic test_reset();
    logic [67:0] outs;
    #1 rst = 1'b1;
    tick();
    tick();
    outs = {grant, enable, rule_out, wa, we, wd, ra, state, screen_cnt};
    total++;
    if (outs !== 68'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    rst = 1'b0;
  endtask

  task automatic test_seed_single();
    logic [15:0] exp_d;
    tick();
    total++;
    if (state !== 3'd1 || rule_out !== 8'd30) begin
      bad++;
      $display("FAIL seed_entry state=%0d rule=%0d want state=1 rule=30", state, rule_out);
    end
    for (int k = 0; k < H; k++) begin
      exp_d = (k == H / 2) ? 16'h0000 : 16'hFF00;
      total++;
      if ({we, wa, wd} !== {1'b1, 11'(k), exp_d}) begin
        bad++;
        $display("FAIL seed_single k=%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h", k, we, wa, wd, k, exp_d);
      end
      tick();
    end
    total++;
    if (state !== 3'd2 || we !== 1'b0) begin
      bad++;
      $display("FAIL seed_single_end state=%0d we=%b want state=2 we=0", state, we);
    end
  endtask

  task automatic test_seed_random();
    logic [15:0] l;
    logic [15:0] exp_d;
    l = 16'hACE1;
    tick();
    total++;
    if (state !== 3'd1 || rule_out !== 8'd110) begin
      bad++;
      $display("FAIL seed_rand_entry state=%0d rule=%0d want state=1 rule=110", state, rule_out);
    end
    for (int k = 0; k < H; k++) begin
      exp_d = l[0] ? 16'h0000 : 16'hFF00;
      total++;
      if ({we, wa, wd} !== {1'b1, 11'(k), exp_d}) begin
        bad++;
        $display("FAIL seed_random k=%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h", k, we, wa, wd, k, exp_d);
      end
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      tick();
    end
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL seed_random_end state=%0d want 2", state);
    end
  endtask

  // Sweeps x/y from (x0,y0); a key press is made mid-DRAW and must be dropped.
  task automatic test_frame(input int x0, input int y0, input int exp_wait, input int exp_count);
    int waited, hi;
    logic early, held;
    logic [2:0] st_last_draw, st_first_drain;
    x = 10'(x0);
    y = 10'(y0);
    sweep_en = 1'b1;
    waited = 0;
    early = 1'b0;
    do begin
      tick();
      waited++;
      if (!(sx == 10'd0 && sy == 10'd0) && state !== 3'd2) early = 1'b1;
    end while (!(sx == 10'd0 && sy == 10'd0) && waited < 200);
    total++;
    if (waited != exp_wait || early !== 1'b0) begin
      bad++;
      $display("FAIL frame_wait waited=%0d early=%b want %0d early=0", waited, early, exp_wait);
    end
    total++;
    if ({state, grant, enable} !== {3'd3, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL draw_entry state=%0d grant=%b en=%b want 3 1 1", state, grant, enable);
    end
    hi = 1;
    st_last_draw = 3'd7;
    st_first_drain = 3'd7;
    while (hi < 200) begin
      if (hi == 10) next_screen = 1'b1;
      if (hi == 20) next_screen = 1'b0;
      tick();
      if (grant !== 1'b1) break;
      hi++;
      if (hi == H * V - 1) st_last_draw = state;
      if (hi == H * V) st_first_drain = state;
    end
    // Grant covers pixels 1..H*V-1 after the frame-start cycle plus PD+1 drain cycles.
    total++;
    if (hi != H * V - 1 + PD + 1) begin
      bad++;
      $display("FAIL grant_length got=%0d want=%0d", hi, H * V + PD);
    end
    total++;
    if (st_last_draw !== 3'd3 || st_first_drain !== 3'd4) begin
      bad++;
      $display("FAIL draw_drain_edge got=%0d,%0d want=3,4", st_last_draw, st_first_drain);
    end
    total++;
    if ({state, enable, we, screen_cnt} !== {3'd5, 1'b0, 1'b0, 16'(exp_count)}) begin
      bad++;
      $display("FAIL hold_entry state=%0d en=%b we=%b cnt=%0d want 5 0 0 %0d", state, enable, we, screen_cnt, exp_count);
    end
    sweep_en = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (state !== 3'd5) held = 1'b0;
    end
    total++;
    if (held !== 1'b1) begin
      bad++;
      $display("FAIL draw_press_dropped left HOLD, state=%0d want 5", state);
    end
  endtask

  // Frame start held at (0,0) through the copy must not be taken until the copy finishes.
  task automatic test_copy();
    int n;
    logic [15:0] exp_d;
    x = 10'd0;
    y = 10'd0;
    next_screen = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (state !== 3'd6 && n < 20);
    next_screen = 1'b0;
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL copy_latency got=%0d want=3", n);
    end
    for (int k = 0; k <= H; k++) begin
      if (k < H) begin
        total++;
        if (ra !== 11'(2 * H + k)) begin
          bad++;
          $display("FAIL copy_read k=%0d got=%0d want=%0d", k, ra, 2 * H + k);
        end
      end
      exp_d = 16'h5A00 | 16'(2 * H + k - 1);
      total++;
      if (k == 0 && we !== 1'b0) begin
        bad++;
        $display("FAIL copy_first_we got=%b want=0", we);
      end else if (k != 0 && {we, wa, wd, state} !== {1'b1, 11'(k - 1), exp_d, 3'd6}) begin
        bad++;
        $display("FAIL copy_write k=%0d got we=%b a=%0d d=%h st=%0d want 1 %0d %h 6", k, we, wa, wd, state, k - 1, exp_d);
      end
      tick();
    end
    total++;
    if (state !== 3'd2 || we !== 1'b0) begin
      bad++;
      $display("FAIL copy_end state=%0d we=%b want 2 0", state, we);
    end
  endtask

  task automatic test_reset_mid();
    logic [67:0] outs;
    int n;
    next_screen = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (state !== 3'd6 && n < 20);
    next_screen = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    outs = {grant, enable, rule_out, wa, we, wd, ra, state, screen_cnt};
    total++;
    if (outs !== 68'd0) begin
      bad++;
      $display("FAIL reset_mid_copy got=%h want=0", outs);
    end
    tick();
    x = 10'd5;
    y = 10'd2;
    rule_in = 8'd30;
    seed_sel = 1'b1;
    rst = 1'b0;
    test_seed_single();
    x = 10'd0;
    y = 10'd0;
    tick();
    total++;
    if (state !== 3'd3 || grant !== 1'b1) begin
      bad++;
      $display("FAIL rerun_draw state=%0d grant=%b want 3 1", state, grant);
    end
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    outs = {grant, enable, rule_out, wa, we, wd, ra, state, screen_cnt};
    total++;
    if (outs !== 68'd0) begin
      bad++;
      $display("FAIL reset_mid_draw got=%h want=0", outs);
    end
    tick();
    x = 10'd5;
    y = 10'd2;
    rule_in = 8'd110;
    seed_sel = 1'b0;
    rst = 1'b0;
  endtask

`ifdef CA_SEQ_DEBOUNCE_EN
  task automatic test_debounce();
    logic stayed;
    int entries;
    logic [2:0] prev;
    next_screen = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    next_screen = 1'b0;
    stayed = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state !== 3'd5) stayed = 1'b0;
    end
    total++;
    if (stayed !== 1'b1) begin
      bad++;
      $display("FAIL debounce_glitch left HOLD, state=%0d want 5", state);
    end
    next_screen = 1'b1;
    entries = 0;
    prev = state;
    for (int i = 0; i < 60; i++) begin
      if (i == 12) next_screen = 1'b0;
      tick();
      if (state == 3'd6 && prev != 3'd6) entries++;
      prev = state;
    end
    total++;
    if (entries != 1) begin
      bad++;
      $display("FAIL debounce_press copies=%0d want=1", entries);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seed_single();
    test_frame(5, 2, 28, 1);
    test_copy();
    test_frame(0, 0, 1, 2);
    test_reset_mid();
    test_seed_random();
    test_frame(5, 2, 28, 1);
`ifdef CA_SEQ_DEBOUNCE_EN
    test_debounce();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
